decode_instruction: RTL and testbench

Decode / register-read stage between instruction fetch and `execute_instruction`. It takes one 32-bit instruction per cycle, reads two operands from the 32×32 register file, and produces the field set the execute stage consumes. It also owns the register-file write port driven by the execute stage's writeback outputs, a one-bubble RAW interlock, and branch flush.

---
 rtl/decode_instruction_pkg.sv | 42 ++++
 rtl/decode_instruction_register_file.sv | 36 +++
 rtl/decode_instruction.sv | 148 ++++++++++++++
 tb/tb_decode_instruction.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_instruction_pkg.sv
// Shared widths, opecode encodings and the decoded-class record for the decode stage.
// Imported by the register file and the decode top.
package decode_instruction_pkg;

    localparam int W_OPC  = 7;
    localparam int W_OPR  = 32;
    localparam int W_RD   = 5;
    localparam int W_IMM  = 16;
    localparam int ADDR   = 16;
    localparam int W_CC   = 5;
    localparam int N_REGS = 32;

    localparam logic [W_OPC-1:0] OPC_NOP  = 7'd30;
    localparam logic [W_OPC-1:0] OPC_LD   = 7'd24;
    localparam logic [W_OPC-1:0] OPC_ST   = 7'd25;
    localparam logic [W_OPC-1:0] OPC_J    = 7'd28;
    localparam logic [W_OPC-1:0] OPC_JA   = 7'd29;
    localparam logic [W_OPC-1:0] OPC_SETL = 7'd22;
    localparam logic [W_OPC-1:0] OPC_SETH = 7'd23;

    // Low five opecode bits of every legal instruction; the upper two must be zero.
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3,
        OP_CMP  = 5'd4,  OP_ABS  = 5'd5,  OP_ADC  = 5'd6,  OP_SBC  = 5'd7,
        OP_SHL  = 5'd8,  OP_SHR  = 5'd9,  OP_ASH  = 5'd10, OP_ROL  = 5'd12,
        OP_ROR  = 5'd13, OP_AND  = 5'd16, OP_OR   = 5'd17, OP_NOT  = 5'd18,
        OP_XOR  = 5'd19, OP_SETL = 5'd22, OP_SETH = 5'd23, OP_LD   = 5'd24,
        OP_ST   = 5'd25, OP_J    = 5'd28, OP_JA   = 5'd29, OP_NOP  = 5'd30,
        OP_HLT  = 5'd31
    } op_e;

    typedef struct packed {
        logic legal;
        logic wb;
        logic immsign;
        logic stf;
        logic reads_ra;
        logic reads_rb;
        logic is_jump;
    } class_t;

endpackage

// File: rtl/decode_instruction_register_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, synchronous clear of every entry on reset.
module decode_instruction_register_file
    import decode_instruction_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [W_RD-1:0]  waddr,
    input  logic [W_OPR-1:0] wdata,
    input  logic [W_RD-1:0]  raddr0,
    input  logic [W_RD-1:0]  raddr1,
    output logic [W_OPR-1:0] rdata0,
    output logic [W_OPR-1:0] rdata1
);

    logic [W_OPR-1:0] regs [N_REGS];

    // NOTE: the array is cleared in reset because software relies on zeroed registers;
    // this rules out plain block-RAM inference, which is acceptable at 32 entries.
    // NOTE: sequential state uses <= so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass lets a consumer issue in the same cycle its producer writes back.
    assign rdata0 = (we && (waddr == raddr0)) ? wdata : regs[raddr0];
    assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];

endmodule

// File: rtl/decode_instruction.sv
// Decode / register-read stage: field extraction, class decode, operand read,
// one-bubble RAW interlock and branch flush, registered towards execute.
module decode_instruction
    import decode_instruction_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              v_i,
    input  logic [ADDR-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    input  logic              stall_i,
    output logic              stall_o,
    input  logic              flush_i,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   wb_r_i,
    input  logic [W_OPR-1:0]  result_i,
    output logic              v_o,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_OPC-1:0]  opecode_o,
    output logic              immf_o,
    output logic              immsign_o,
    output logic [W_IMM-1:0]  imm_o,
    output logic              stf_o,
    output logic [W_OPR-1:0]  opr0_o,
    output logic [W_OPR-1:0]  opr1_o,
    output logic              wb_o,
    output logic [W_RD-1:0]   wb_r_o
);

    function automatic class_t decode_class(input logic [W_OPC-1:0] opc, input logic immf);
        class_t c;
        c = '0;
        c.legal = 1'b1;
        if (opc[6:5] != 2'b00) begin
            c.legal = 1'b0;
        end else begin
            case (opc[4:0])
                OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ABS, OP_ADC, OP_SBC: begin
                    c.wb      = 1'b1;
                    c.immsign = 1'b1;
                end
                OP_CMP: c.immsign = 1'b1;
                OP_SHL, OP_SHR, OP_ASH, OP_ROL, OP_ROR,
                OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SETL, OP_SETH: c.wb = 1'b1;
                OP_LD: begin
                    c.wb      = 1'b1;
                    c.immsign = 1'b1;
                end
                OP_ST: begin
                    c.immsign = 1'b1;
                    c.stf     = 1'b1;
                end
                OP_J, OP_JA: begin
                    c.immsign = 1'b1;
                    c.is_jump = 1'b1;
                end
                OP_NOP, OP_HLT: ;
                default: c.legal = 1'b0;
            endcase
        end
        c.reads_ra = c.legal && !(opc[4:0] inside {OP_ABS, OP_J, OP_JA, OP_NOP, OP_HLT});
        c.reads_rb = c.legal && !immf && !(opc[4:0] inside {OP_SETL, OP_SETH, OP_NOP, OP_HLT});
        return c;
    endfunction

    logic [W_OPC-1:0] opc;
    logic             immf;
    logic [W_RD-1:0]  ra;
    logic [W_RD-1:0]  rb;
    logic [W_IMM-1:0] imm;

    assign opc  = inst_i[31:25];
    assign immf = inst_i[24];
    assign ra   = inst_i[23:19];
    assign rb   = inst_i[18:14];
    assign imm  = inst_i[15:0];

    logic [W_OPR-1:0] rdata0;
    logic [W_OPR-1:0] rdata1;

    decode_instruction_register_file u_register_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_i),
        .waddr  (wb_r_i),
        .wdata  (result_i),
        .raddr0 (ra),
        .raddr1 (rb),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    class_t           cls;
    logic [W_OPC-1:0] opecode_d;
    logic [W_OPR-1:0] opr0_d;
    logic             hz;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        cls       = decode_class(opc, immf);
        opecode_d = OPC_NOP;
        opr0_d    = rdata0;
        if (cls.legal) begin
            opecode_d = opc;
        end
        if (cls.is_jump) begin
            opr0_d = {{(W_OPR-W_CC){1'b0}}, ra[W_CC-1:0]};
        end
        hz = v_i && v_o && wb_o &&
             ((cls.reads_ra && (ra == wb_r_o)) || (cls.reads_rb && (rb == wb_r_o)));
    end

    assign stall_o = !reset && (stall_i || (hz && !flush_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            v_o       <= 1'b0;
            pc_o      <= '0;
            opecode_o <= OPC_NOP;
            immf_o    <= 1'b0;
            immsign_o <= 1'b0;
            imm_o     <= '0;
            stf_o     <= 1'b0;
            opr0_o    <= '0;
            opr1_o    <= '0;
            wb_o      <= 1'b0;
            wb_r_o    <= '0;
        end else if (stall_i) begin
            // Execute is frozen; a pending flush stays asserted until it releases.
        end else if (flush_i || hz) begin
            v_o <= 1'b0;
        end else begin
            v_o       <= v_i;
            pc_o      <= pc_i;
            opecode_o <= opecode_d;
            immf_o    <= immf;
            immsign_o <= cls.immsign;
            imm_o     <= imm;
            stf_o     <= cls.stf;
            opr0_o    <= opr0_d;
            opr1_o    <= rdata1;
            wb_o      <= cls.wb;
            wb_r_o    <= ra;
        end
    end

endmodule

// File: tb/tb_decode_instruction.sv
// Directed self-checking bench for decode_instruction: hand-computed vectors,
// immediate assertions at each comparison point.
module tb_decode_instruction;

    logic        clk;
    logic        reset;
    logic        v_i;
    logic [15:0] pc_i;
    logic [31:0] inst_i;
    logic        stall_i;
    logic        stall_o;
    logic        flush_i;
    logic        wb_i;
    logic [4:0]  wb_r_i;
    logic [31:0] result_i;
    logic        v_o;
    logic [15:0] pc_o;
    logic [6:0]  opecode_o;
    logic        immf_o;
    logic        immsign_o;
    logic [15:0] imm_o;
    logic        stf_o;
    logic [31:0] opr0_o;
    logic [31:0] opr1_o;
    logic        wb_o;
    logic [4:0]  wb_r_o;

    int checks = 0;
    int errors = 0;

    decode_instruction dut (
        .clk       (clk),
        .reset     (reset),
        .v_i       (v_i),
        .pc_i      (pc_i),
        .inst_i    (inst_i),
        .stall_i   (stall_i),
        .stall_o   (stall_o),
        .flush_i   (flush_i),
        .wb_i      (wb_i),
        .wb_r_i    (wb_r_i),
        .result_i  (result_i),
        .v_o       (v_o),
        .pc_o      (pc_o),
        .opecode_o (opecode_o),
        .immf_o    (immf_o),
        .immsign_o (immsign_o),
        .imm_o     (imm_o),
        .stf_o     (stf_o),
        .opr0_o    (opr0_o),
        .opr1_o    (opr1_o),
        .wb_o      (wb_o),
        .wb_r_o    (wb_r_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic immf,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [15:0] imm);
        logic [31:0] w;
        w = {opc, immf, ra, 19'b0};
        if (immf) w[15:0] = imm;
        else      w[18:14] = rb;
        return w;
    endfunction

    initial begin
        reset = 1'b1; v_i = 1'b0; pc_i = '0; inst_i = '0; stall_i = 1'b0;
        flush_i = 1'b0; wb_i = 1'b0; wb_r_i = '0; result_i = '0;
        tick();
        tick();
        check("rst_v", v_o, 0);
        check("rst_opc", opecode_o, 7'd30);
        check("rst_wb", wb_o, 0);
        check("rst_opr0", opr0_o, 0);
        check("rst_stall", stall_o, 0);

        // ADD r1,#5
        reset = 1'b0;
        v_i = 1'b1; pc_i = 16'h0010; inst_i = mk(7'd0, 1'b1, 5'd1, 5'd0, 16'h0005);
        tick();
        check("add_v", v_o, 1);
        check("add_opc", opecode_o, 0);
        check("add_imm", imm_o, 5);
        check("add_immsign", immsign_o, 1);
        check("add_wb", wb_o, 1);
        check("add_wbr", wb_r_o, 1);
        check("add_pc", pc_o, 16'h0010);

        // ADD r2,r1 depends on r1 -> one bubble, then bypass
        pc_i = 16'h0011; inst_i = mk(7'd0, 1'b0, 5'd2, 5'd1, 16'h0);
        #1;
        check("raw_stall_o", stall_o, 1);
        tick();
        check("raw_bubble_v", v_o, 0);
        wb_i = 1'b1; wb_r_i = 5'd1; result_i = 32'h0000_0007;
        #1;
        check("raw_release", stall_o, 0);
        tick();
        check("raw_v", v_o, 1);
        check("raw_opr1_bypass", opr1_o, 32'h7);
        check("raw_opr0", opr0_o, 32'h0);
        check("raw_pc", pc_o, 16'h0011);

        // write r3=0x40, idle slot
        v_i = 1'b0; wb_i = 1'b1; wb_r_i = 5'd3; result_i = 32'h40;
        tick();
        check("idle_v", v_o, 0);

        // J cc=5, rb=r3
        wb_i = 1'b0; v_i = 1'b1; pc_i = 16'h0020; inst_i = mk(7'd28, 1'b0, 5'd5, 5'd3, 16'h0);
        tick();
        check("j_opr0", opr0_o, 32'd5);
        check("j_opr1", opr1_o, 32'h40);
        check("j_wb", wb_o, 0);
        check("j_opc", opecode_o, 7'd28);

        // ADD r6,#1 then dependent ADD r7,r6 arriving with flush
        pc_i = 16'h0021; inst_i = mk(7'd0, 1'b1, 5'd6, 5'd0, 16'h0001);
        tick();
        check("add6_v", v_o, 1);
        pc_i = 16'h0022; inst_i = mk(7'd0, 1'b0, 5'd7, 5'd6, 16'h0); flush_i = 1'b1;
        #1;
        check("flush_stall_o", stall_o, 0);
        tick();
        check("flush_v", v_o, 0);
        check("flush_pc_held", pc_o, 16'h0021);
        flush_i = 1'b0;

        // ADD r8,#0x11 then 3 stall cycles with writeback r4=9 and a held flush
        pc_i = 16'h0030; inst_i = mk(7'd0, 1'b1, 5'd8, 5'd0, 16'h0011);
        tick();
        check("add8_v", v_o, 1);
        pc_i = 16'h0031; inst_i = mk(7'd17, 1'b0, 5'd10, 5'd4, 16'h0);
        stall_i = 1'b1; flush_i = 1'b1; wb_i = 1'b1; wb_r_i = 5'd4; result_i = 32'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_o", stall_o, 1);
            tick();
            check("stall_v", v_o, 1);
            check("stall_pc", pc_o, 16'h0030);
            check("stall_imm", imm_o, 16'h0011);
            check("stall_wbr", wb_r_o, 8);
            wb_i = 1'b0;
        end
        stall_i = 1'b0; flush_i = 1'b0;
        tick();
        check("or_v", v_o, 1);
        check("or_opc", opecode_o, 7'd17);
        check("or_r4", opr1_o, 32'd9);

        // illegal opecodes decode as NOP
        pc_i = 16'h0040; inst_i = mk(7'b110_0000, 1'b0, 5'd10, 5'd0, 16'h0);
        #1;
        check("ill_no_hz", stall_o, 0);
        tick();
        check("ill_opc", opecode_o, 7'd30);
        check("ill_wb", wb_o, 0);
        check("ill_v", v_o, 1);
        inst_i = mk(7'd11, 1'b1, 5'd2, 5'd0, 16'h0);
        tick();
        check("ill11_opc", opecode_o, 7'd30);
        check("ill11_wb", wb_o, 0);
        check("ill11_immsign", immsign_o, 0);

        // CMP r1,r1 then ADD r1 -> no bubble
        inst_i = mk(7'd4, 1'b0, 5'd1, 5'd1, 16'h0);
        tick();
        check("cmp_wb", wb_o, 0);
        check("cmp_opr0", opr0_o, 32'h7);
        check("cmp_opr1", opr1_o, 32'h7);
        inst_i = mk(7'd0, 1'b1, 5'd1, 5'd0, 16'h0003);
        #1;
        check("cmp_no_hz", stall_o, 0);
        tick();
        check("cmp_add_v", v_o, 1);

        // LD r5 then ST r5 -> one bubble, load data via bypass
        inst_i = mk(7'd24, 1'b1, 5'd5, 5'd0, 16'h0000);
        tick();
        check("ld_wb", wb_o, 1);
        inst_i = mk(7'd25, 1'b1, 5'd5, 5'd0, 16'h0004);
        #1;
        check("ld_use_stall", stall_o, 1);
        tick();
        check("ld_use_v", v_o, 0);
        wb_i = 1'b1; wb_r_i = 5'd5; result_i = 32'hAB;
        tick();
        check("st_v", v_o, 1);
        check("st_stf", stf_o, 1);
        check("st_wb", wb_o, 0);
        check("st_opr0", opr0_o, 32'hAB);
        wb_i = 1'b0;

        // reset during stall clears outputs and register file
        stall_i = 1'b1; reset = 1'b1;
        #1;
        check("rst_stall_o", stall_o, 0);
        tick();
        check("rst2_v", v_o, 0);
        check("rst2_opc", opecode_o, 7'd30);
        stall_i = 1'b0; reset = 1'b0;
        inst_i = mk(7'd16, 1'b0, 5'd1, 5'd4, 16'h0);
        tick();
        check("clr_r1", opr0_o, 0);
        check("clr_r4", opr1_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
